acc_result_serializer: RTL and testbench

Readout side of the MAC accumulator. Captures the 34-bit parallel accumulator output on a load strobe and unloads it LSB-first as fixed-width beats over a valid/ready stream. This gives downstream logic, such as a bus bridge or host FIFO, a narrow, flow-controlled read path to the MAC result without waiting on the full parallel word.

---
 rtl/acc_result_serializer_if.sv | 31 +++
 rtl/acc_result_serializer.sv | 102 ++++++++++
 tb/tb_acc_result_serializer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_result_serializer_if.sv
// Beat stream between the accumulator serializer (master) and its consumer (slave).
// ACC_SER_PARITY_EN adds the even-parity sideband s_par.
interface acc_result_serializer_if #(
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned IDX_W  = 3
);
  logic              s_valid;
  logic              s_ready;
  logic [BEAT_W-1:0] s_data;
  logic              s_last;
  logic [IDX_W-1:0]  s_idx;
`ifdef ACC_SER_PARITY_EN
  logic              s_par;
`endif

  modport master (
    output s_valid, s_data, s_last, s_idx,
`ifdef ACC_SER_PARITY_EN
    output s_par,
`endif
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_last, s_idx,
`ifdef ACC_SER_PARITY_EN
    input  s_par,
`endif
    output s_ready
  );
endinterface

// File: rtl/acc_result_serializer.sv
// Captures the MAC accumulator word on load and unloads it LSB-first as beats.
// ACC_SER_PARITY_EN adds an even-parity bit per beat on s_par.
module acc_result_serializer #(
  parameter int unsigned DATA_W = 34,
  parameter int unsigned BEAT_W = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   load,
  input  logic [DATA_W-1:0]      acc_in,
  output logic                   busy,
  acc_result_serializer_if.master s
);
  localparam int unsigned BEATS = (DATA_W + BEAT_W - 1) / BEAT_W;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SH_W  = BEATS * BEAT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [BEATS-1:0][BEAT_W-1:0] shadow_q, shadow_d;
  logic [BEAT_W-1:0]            data_q, data_d;
  logic                         last_q, last_d;

  // State and output registers; clr clears everything immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  // Next-state and next-output logic; data/last are precomputed for the beat shown next cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d  = SEND;
          idx_d    = '0;
          shadow_d = SH_W'(acc_in);
          data_d   = acc_in[BEAT_W-1:0];
          last_d   = (BEATS == 1);
        end
      end
      SEND: begin
        if (s.s_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = shadow_q[idx_d];
            last_d = (idx_d == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        data_d  = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q == SEND);
  assign s.s_valid = (state_q == SEND);
  assign s.s_data  = data_q;
  assign s.s_last  = last_q;
  assign s.s_idx   = idx_q;

`ifdef ACC_SER_PARITY_EN
  logic par_q;

  // Parity is registered alongside the beat so it shares its stability.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) par_q <= 1'b0;
    else     par_q <= ^data_d;
  end

  assign s.s_par = par_q;
`endif
endmodule

// File: tb/tb_acc_result_serializer.sv
// Self-checking bench: queue-based beat model, per-cycle compare, directed and random stimulus.
module tb_acc_result_serializer;
  localparam int unsigned DATA_W = 34;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned BEATS  = 5;
  localparam int unsigned IDX_W  = 3;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              load = 1'b0;
  logic [DATA_W-1:0] acc_in = '0;
  logic              busy;

  acc_result_serializer_if #(.BEAT_W(BEAT_W), .IDX_W(IDX_W)) bus ();

  acc_result_serializer #(.DATA_W(DATA_W), .BEAT_W(BEAT_W)) dut (
    .clk    (clk),
    .clr    (clr),
    .load   (load),
    .acc_in (acc_in),
    .busy   (busy),
    .s      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } beat_t;

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              par;
    int                cyc;
  } obs_t;

  beat_t mq[$];
  obs_t  obs[$];
  int    compared = 0;
  int    mismatched = 0;
  int    cyc = 0;
  int    vcnt = 0;
  int    idx2cnt = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes a queue of beats; each handshake pops one.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mq.delete();
    end else begin
      if (mq.size() == 0) begin
        if (load) begin
          logic [63:0] w;
          w = 64'(acc_in);
          for (int b = 0; b < int'(BEATS); b++) begin
            beat_t bt;
            bt.data = BEAT_W'(w >> (b * int'(BEAT_W)));
            bt.idx  = IDX_W'(b);
            bt.last = (b == int'(BEATS) - 1);
            mq.push_back(bt);
          end
        end
      end else if (bus.s_ready) begin
        void'(mq.pop_front());
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (mq.size() == 0) begin
      check("idle_valid", 64'(bus.s_valid), 0);
      check("idle_busy", 64'(busy), 0);
      check("idle_data", 64'(bus.s_data), 0);
      check("idle_idx", 64'(bus.s_idx), 0);
      check("idle_last", 64'(bus.s_last), 0);
`ifdef ACC_SER_PARITY_EN
      check("idle_par", 64'(bus.s_par), 0);
`endif
    end else begin
      check("valid", 64'(bus.s_valid), 1);
      check("busy", 64'(busy), 1);
      check("data", 64'(bus.s_data), 64'(mq[0].data));
      check("idx", 64'(bus.s_idx), 64'(mq[0].idx));
      check("last", 64'(bus.s_last), 64'(mq[0].last));
`ifdef ACC_SER_PARITY_EN
      check("par", 64'(bus.s_par), 64'(^mq[0].data));
`endif
    end
    if (bus.s_valid) vcnt++;
    if (bus.s_valid && bus.s_idx == 3'd2) idx2cnt++;
    if (bus.s_valid && bus.s_ready) begin
      obs_t o;
      o.data = bus.s_data;
      o.idx  = bus.s_idx;
`ifdef ACC_SER_PARITY_EN
      o.par  = bus.s_par;
`else
      o.par  = 1'b0;
`endif
      o.cyc  = cyc;
      obs.push_back(o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #2;
    clr = 1'b0;
    tick();
  endtask

  task automatic check_stream(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] exp [5];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3; exp[4] = e4;
    check({name, "_count"}, longint'(obs.size()), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs.size()) begin
        check({name, "_beat"}, 64'(obs[i].data), 64'(exp[i]));
        check({name, "_bidx"}, 64'(obs[i].idx), 64'(i));
      end
    end
  endtask

  initial begin
    bus.s_ready = 1'b0;
    #1;
    clr = 1'b1;
    #1;
    check("reset_valid", 64'(bus.s_valid), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_data", 64'(bus.s_data), 0);
    clr = 1'b0;
    tick();

    // Basic unload
    bus.s_ready = 1'b1;
    obs.delete();
    acc_in = 34'h2_DEAD_BEEF;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("basic_busy_n1", 64'(busy), 1);
    repeat (5) tick();
    check("basic_busy_after", 64'(busy), 0);
    check_stream("basic", 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h02);
    tick();

    // Backpressure on beat 2
    obs.delete();
    vcnt = 0;
    idx2cnt = 0;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    bus.s_ready = 1'b0;
    repeat (3) tick();
    bus.s_ready = 1'b1;
    repeat (5) tick();
    check("bp_valid_cycles", longint'(vcnt), 8);
    check("bp_beat2_cycles", longint'(idx2cnt), 4);
    check_stream("bp", 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h02);

    // Load while busy is ignored, including on the last-beat edge
    obs.delete();
    acc_in = 34'h0_0000_0001;
    load = 1'b1;
    tick();
    load = 1'b0;
    acc_in = 34'h3_FFFF_FFFF;
    tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    check_stream("lwb", 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);

    // Asynchronous clear mid-word
    acc_in = 34'h1_2345_6789;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    check("pre_clr_idx", 64'(bus.s_idx), 2);
    #2;
    clr = 1'b1;
    #1;
    check("clr_valid", 64'(bus.s_valid), 0);
    check("clr_busy", 64'(busy), 0);
    check("clr_data", 64'(bus.s_data), 0);
    check("clr_idx", 64'(bus.s_idx), 0);
    tick();
    clr = 1'b0;
    obs.delete();
    acc_in = 34'h0_0000_00AA;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (6) tick();
    check_stream("post_clr", 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00);

    // Back-to-back words with load held high
    obs.delete();
    acc_in = 34'h0_1111_2222;
    load = 1'b1;
    repeat (7) tick();
    acc_in = 34'h0_3333_4444;
    repeat (6) tick();
    load = 1'b0;
    repeat (6) tick();
    check("b2b_count", longint'(obs.size()), 15);
    if (obs.size() >= 7) begin
      check("b2b_a0", 64'(obs[0].idx), 0);
      check("b2b_b0", 64'(obs[5].idx), 0);
      check("b2b_gap", longint'(obs[5].cyc - obs[0].cyc), longint'(BEATS + 1));
      check("b2b_b0_data", 64'(obs[5].data), 64'h22);
    end

`ifdef ACC_SER_PARITY_EN
    obs.delete();
    acc_in = 34'h0_0000_0107;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (6) tick();
    check_stream("par", 8'h07, 8'h01, 8'h00, 8'h00, 8'h00);
    if (obs.size() == 5) begin
      check("par_b0", 64'(obs[0].par), 1);
      check("par_b1", 64'(obs[1].par), 1);
      check("par_b2", 64'(obs[2].par), 0);
    end
`endif

    // Random traffic with occasional clear
    for (int i = 0; i < 2000; i++) begin
      logic [63:0] tmp;
      tmp = {$urandom(), $urandom()};
      acc_in = tmp[33:0];
      load = ($urandom_range(0, 3) == 0);
      bus.s_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) clr = 1'b1;
      tick();
      clr = 1'b0;
    end
    load = 1'b0;
    bus.s_ready = 1'b1;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
